// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// Each grant is bounded to MAX_BURST words; FULL stalls the owner without losing its grant.
module fifo_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqData,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(NUM_REQ)-1:0]      grantId,
  output logic                            busy,
  output logic                            WR,
  output logic [DATA_WIDTH-1:0]           wrData,
  input  logic                            FULL
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_id;
  logic [CNT_W-1:0]   burst_cnt;

  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic                  owner_req;
  logic                  release_c;
  logic [ID_W:0]         pick_c;

  // Search starts just after 'last' and wraps, so 'last' itself is checked only at the end.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last) + i) % NUM_REQ;
      if (!res[ID_W] && r[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = reqData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Write strobe, ack and data mux; Rst gates the strobe so a word in the reset cycle is dropped.
  always_comb begin
    owner_req = req[grantId];
    WR        = (state == GRANT) && owner_req && !FULL && !Rst;
    ack       = '0;
    if (WR) ack = NUM_REQ'(1) << grantId;
    wrData    = (state == GRANT) ? words[grantId] : '0;
    release_c = (state == GRANT) &&
                (!owner_req || (WR && (burst_cnt == CNT_W'(MAX_BURST - 1))));
    pick_c    = rr_pick(req, (state == GRANT) ? grantId : last_id);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      grant     <= '0;
      grantId   <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_c[ID_W]) begin
            state     <= GRANT;
            busy      <= 1'b1;
            grantId   <= pick_c[ID_W-1:0];
            grant     <= NUM_REQ'(1) << pick_c[ID_W-1:0];
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            last_id <= grantId;
            if (pick_c[ID_W]) begin
              grantId   <= pick_c[ID_W-1:0];
              grant     <= NUM_REQ'(1) << pick_c[ID_W-1:0];
              burst_cnt <= '0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              grant     <= '0;
              grantId   <= '0;
              burst_cnt <= '0;
            end
          end else if (WR) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: expected FIFO words are queued as stimulus is
// applied and popped by a write monitor; grant/strobe behaviour is asserted at each step.
module tb_fifo_write_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned MB = 4;

  logic             Clk;
  logic             Rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    grant;
  logic [1:0]       grantId;
  logic             busy;
  logic             WR;
  logic [DW-1:0]    wrData;
  logic             FULL;

  logic             clr;
  int               pcnt [NR];
  logic [DW-1:0]    exp_q [$];
  int               checks;
  int               errors;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .reqData(reqData), .ack(ack), .grant(grant),
    .grantId(grantId), .busy(busy), .WR(WR), .wrData(wrData), .FULL(FULL)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Producer model: producer i offers 8'h10*i plus its ack count modulo the burst length.
  always @(posedge Clk) begin
    for (int i = 0; i < NR; i++) begin
      if (clr) pcnt[i] <= 0;
      else if (ack[i]) pcnt[i] <= pcnt[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 8'(16 * i + pcnt[i] % MB);
  end

  // FIFO-side monitor: every write must match the head of the expected queue.
  always @(negedge Clk) begin
    checks++;
    assert ((WR & FULL) !== 1'b1) else begin
      errors++;
      $error("FAIL wr_while_full: WR=%b FULL=%b expected WR=0", WR, FULL);
    end
    if (WR === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: wrData=%h expected no write", wrData);
      end
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (wrData === e) else begin
          errors++;
          $error("FAIL write_data: got %h expected %h", wrData, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_burst(input int p, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(16 * p + k % MB));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst  = 1'b1;
    req  = '1;
    FULL = 1'b0;
    clr  = 1'b1;

    // Reset with all requesters active
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grantid", 32'(grantId), 32'h0);
    chk("rst_wr", 32'(WR), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_wrdata", 32'(wrData), 32'h0);

    // Full rotation plus a second burst for producer 0
    for (int p = 0; p < NR; p++) push_burst(p, MB);
    push_burst(0, MB);
    Rst = 1'b0;
    clr = 1'b0;
    tick();
    chk("rr_first_grant", 32'(grant), 32'h1);
    chk("rr_first_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 5 * MB; k++) begin
      chk("rr_wr_continuous", 32'(WR), 32'h1);
      tick();
    end
    chk("rr_handover_to_1", 32'(grant), 32'h2);
    req = '0;
    #1;
    chk("rr_drop_wr", 32'(WR), 32'h0);
    tick();
    chk("rr_idle_busy", 32'(busy), 32'h0);
    chk("rr_queue_empty", 32'(exp_q.size()), 32'h0);

    // Early release: producer 2 drops after two acks
    push_burst(2, 2);
    req = 4'b0100;
    tick();
    chk("er_grant", 32'(grant), 32'h4);
    chk("er_grantid", 32'(grantId), 32'h2);
    tick();
    tick();
    req = '0;
    #1;
    chk("er_no_third_wr", 32'(WR), 32'h0);
    tick();
    chk("er_idle_busy", 32'(busy), 32'h0);
    chk("er_idle_grant", 32'(grant), 32'h0);
    chk("er_queue_empty", 32'(exp_q.size()), 32'h0);
    req = 4'b1010;
    tick();
    chk("er_next_winner", 32'(grantId), 32'h3);
    chk("er_next_grant", 32'(grant), 32'h8);
    req = '0;
    #1;
    chk("er_drop_ack", 32'(ack), 32'h0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // FULL stall in the middle of producer 1's burst
    push_burst(1, MB);
    req = 4'b0110;
    tick();
    chk("fs_grant", 32'(grant), 32'h2);
    tick();
    tick();
    FULL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fs_wr_low", 32'(WR), 32'h0);
      chk("fs_ack_low", 32'(ack), 32'h0);
      chk("fs_grant_held", 32'(grant), 32'h2);
      chk("fs_burst_held", 32'(dut.burst_cnt), 32'h2);
      tick();
    end
    FULL = 1'b0;
    tick();
    tick();
    chk("fs_moves_on", 32'(grant), 32'h4);
    chk("fs_queue_empty", 32'(exp_q.size()), 32'h0);
    req = '0;
    tick();
    chk("fs_idle_busy", 32'(busy), 32'h0);

    // Single requester is re-granted back to back
    push_burst(3, 3 * MB);
    req = 4'b1000;
    tick();
    for (int k = 0; k < 3 * MB; k++) begin
      chk("sr_wr_continuous", 32'(WR), 32'h1);
      chk("sr_grant", 32'(grant), 32'h8);
      tick();
    end
    req = '0;
    #1;
    chk("sr_stop_wr", 32'(WR), 32'h0);
    tick();
    chk("sr_queue_empty", 32'(exp_q.size()), 32'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Reset during producer 2's third word
    push_burst(2, 2);
    req = 4'b0100;
    tick();
    chk("rm_grant", 32'(grant), 32'h4);
    tick();
    tick();
    Rst = 1'b1;
    #1;
    chk("rm_wr_gated", 32'(WR), 32'h0);
    chk("rm_ack_gated", 32'(ack), 32'h0);
    tick();
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_grant_clr", 32'(grant), 32'h0);
    Rst = 1'b0;
    req = 4'b0101;
    tick();
    chk("rm_p0_first", 32'(grantId), 32'h0);
    chk("rm_p0_grant", 32'(grant), 32'h1);
    req = '0;
    tick();
    tick();
    chk("rm_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares the write port of one synchronous FIFO among NUM_REQ producers. Each producer presents a request and a data word. The arbiter grants one producer at a time, for a bounded burst, and drives the FIFO's WR/dataIn port, honouring FULL. It sits directly in front of the FIFO and is the only agent allowed to drive the FIFO write port.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each data word; must match the FIFO.
- NUM_REQ, 4, number of producers; legal range 2..8.
- MAX_BURST, 4, maximum words accepted per grant; legal range 1..15.

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-producer request; bit i high means producer i has a word on its data slice.
- reqData  input  NUM_REQ*DATA_WIDTH  producer words; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-hot or zero, combinational; bit i high means producer i's word is written this cycle.
- grant  output  NUM_REQ  registered; one-hot or zero; the current owner.
- grantId  output  $clog2(NUM_REQ)  registered binary index of the owner; 0 when idle.
- busy  output  1  registered; high while in state GRANT.
- WR  output  1  FIFO write strobe, combinational.
- wrData  output  DATA_WIDTH  FIFO write data; equals the owner's reqData slice, or 0 when idle.
- FULL  input  1  FIFO full flag.

## Operation
- State machine with two states: IDLE and GRANT.
- Registers:
  - state
  - grantId
  - grant
  - lastId, the previous owner
  - burstCnt, 4 bits
- IDLE:
  - If req is nonzero, pick a winner by round-robin. The search starts at (lastId+1) mod NUM_REQ and increments, wrapping.
  - On that edge: load grant/grantId with the winner, clear burstCnt, go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT, with owner g:
  - WR = req[g] & !FULL.
  - ack[g] = WR; all other ack bits are 0.
  - wrData = reqData slice g. A word is transferred exactly when WR is high.
  - When WR is high, burstCnt increments by 1.
  - Release happens when either of these is true:
    - req[g] is low, or
    - WR is high and burstCnt == MAX_BURST-1 (this is the last word of the burst).
  - On a release edge:
    - lastId <= g.
    - Re-arbitrate immediately over req with g excluded, plus req[g] only if no other bit is set. This makes g the lowest priority.
    - If there is a winner: stay in GRANT with the new owner and clear burstCnt.
    - If there is none: go to IDLE and clear grant, grantId and burstCnt.
  - FULL stall: the owner keeps its grant indefinitely, burstCnt holds, and WR stays low. There is no timeout.
- Producers must hold their word stable and keep req high until ack. A producer that drops req while it is the owner forfeits the grant.
- Invariant: WR is never high while FULL is high. This makes the arbiter safe for a FIFO that silently drops writes when full.
- Reset (Rst high at an edge), from either state, including mid-burst:
  - state=IDLE, grant=0, grantId=0, busy=0, burstCnt=0.
  - lastId=NUM_REQ-1, so producer 0 wins first after reset.
  - Combinational outputs follow: WR=0, ack=0, wrData=0.
  - A word presented in the cycle Rst is high is not written.

## Timing
- Request-to-first-write latency from IDLE is 1 cycle:
  - req rises before edge N.
  - grant and busy are visible after edge N.
  - WR/ack are high in cycle N+1 if FULL is low; the word is written at edge N+1.
- Owner handover takes 0 bubble cycles: the new owner can write in the cycle right after the old owner's final write.
- Best-case throughput is 1 word per cycle, sustained across owners.
- Fairness: with all producers requesting continuously and FULL low, each gets exactly MAX_BURST words per rotation. The order is 0,1,...,NUM_REQ-1, then repeats.
- ack and WR are combinational from req, FULL and registered grant. They have no combinational path from reqData.

## Test plan
- Reset:
  - Assert Rst for 2 cycles with all req high → grant=0, busy=0, WR=0, ack=0.
  - Release Rst → producer 0 is granted after the next edge.
- Round-robin bursts (MAX_BURST=4, all 4 req high, FULL=0, producer i sends 8'h10*i plus its burst count):
  - FIFO receives 00,01,02,03,10,11,12,13,20..23,30..33,00...
  - WR is high every cycle after the first.
- Early release:
  - Producer 2 alone requests and drops req after 2 acks → exactly 2 words written.
  - Then IDLE with busy=0 next cycle, and lastId=2.
  - Producers 1 and 3 then request → 3 wins.
- FULL stall:
  - FULL is raised mid-burst after producer 1's second word and held 5 cycles → WR=0 and ack=0 for all 5 cycles, grant stays on 1, burstCnt holds at 2.
  - After FULL drops, exactly 2 more words come from producer 1, then the grant moves on.
- Single requester:
  - Only producer 3 requests continuously → it is re-granted after each 4-word burst with no bubble, and WR is continuously high.
- Reset mid-burst:
  - Rst is asserted during producer 2's third word → that word is not written and the arbiter is IDLE.
  - After Rst is released, producer 0 wins ahead of 2 when both request.
